cc_stream_tx: RTL and testbench

// Atlas-bus Command & Control serializer: the transmit end of the CC pin that Mercury decodes.

---
 rtl/cc_stream_tx.sv | 159 +++++++++++++++
 tb/tb_cc_stream_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_stream_tx.sv
// Atlas-bus C&C serializer: takes parallel words over valid/ready and shifts one word
// per CLRCLK frame onto CC, MSB first, one bit per synchronized CBCLK falling edge.
module cc_stream_tx #(
  parameter int BITS   = 59,
  parameter bit REPEAT = 1'b1
) (
  input  logic            CLK_MCLK,
  input  logic            reset,
  input  logic            CBCLK,
  input  logic            CLRCLK,
  input  logic [BITS-1:0] cc_data,
  input  logic            cc_valid,
  output logic            cc_ready,
  output logic            CC,
  output logic            frame_start,
  output logic            busy,
  output logic            frame_err
);

  localparam int            CW       = $clog2(BITS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cb_sync_q, lr_sync_q;
  logic [BITS-1:0]   shift_q, shift_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [BITS-1:0]   hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [BITS-1:0]   last_q, last_d;
  logic              cc_q, cc_d;
  logic              ready_q, ready_d;
  logic              fs_q, fs_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              cb_fall, lr_fall;
  logic              load, bypass;
  logic [BITS-1:0]   commit_word;

  // [0],[1] form the 2-FF synchronizer; [2] is the previous synced level for edge detect
  always_ff @(posedge CLK_MCLK) begin
    if (reset) begin
      cb_sync_q <= '0;
      lr_sync_q <= '0;
    end else begin
      cb_sync_q <= {cb_sync_q[1:0], CBCLK};
      lr_sync_q <= {lr_sync_q[1:0], CLRCLK};
    end
  end

  assign cb_fall = cb_sync_q[2] & ~cb_sync_q[1];
  assign lr_fall = lr_sync_q[2] & ~lr_sync_q[1];

  assign load   = cc_valid & ready_q;
  assign bypass = lr_fall & ~hold_full_q & cc_valid;

  always_comb begin
    commit_word = REPEAT ? last_q : '0;
    if (hold_full_q)   commit_word = hold_q;
    else if (cc_valid) commit_word = cc_data;
  end

  always_ff @(posedge CLK_MCLK) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (lr_fall) begin
      state_d = (cb_fall && BITS == 1) ? S_DONE : S_SHIFT;
    end else if (cb_fall) begin
      case (state_q)
        S_SHIFT: if (bit_cnt_q == LAST_CNT) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_d      = last_q;
    cc_d        = cc_q;
    fs_d        = 1'b0;
    err_d       = 1'b0;

    if (load && !bypass) begin
      hold_d      = cc_data;
      hold_full_d = 1'b1;
    end

    if (lr_fall) begin
      // a new frame always wins; an unfinished SHIFT is abandoned and flagged
      err_d       = (state_q == S_SHIFT);
      fs_d        = 1'b1;
      last_d      = commit_word;
      hold_full_d = 1'b0;
      if (cb_fall) begin
        cc_d      = commit_word[BITS-1];
        shift_d   = commit_word << 1;
        bit_cnt_d = CW'(1);
      end else begin
        shift_d   = commit_word;
        bit_cnt_d = '0;
      end
    end else if (cb_fall) begin
      case (state_q)
        S_SHIFT: begin
          cc_d      = shift_q[BITS-1];
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
        default: cc_d = 1'b0;
      endcase
    end

    ready_d = ~hold_full_d;
    busy_d  = (state_d == S_SHIFT);
  end

  always_ff @(posedge CLK_MCLK) begin
    if (reset) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      last_q      <= '0;
      cc_q        <= 1'b0;
      ready_q     <= 1'b1;
      fs_q        <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      last_q      <= last_d;
      cc_q        <= cc_d;
      ready_q     <= ready_d;
      fs_q        <= fs_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign cc_ready    = ready_q;
  assign CC          = cc_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_cc_stream_tx.sv
// Scoreboard bench for cc_stream_tx: three instances (default, REPEAT=0, BITS=70)
// share one bus clock generator; monitors pop expected words on each frame_start.
module tb_cc_stream_tx;

  logic clk;
  logic cbclk, lrclk, lr_prev;
  logic [8:0] bus_cnt;
  int lr_cnt;

  logic rst_m, rst_r, rst_o;
  logic [58:0] data_m, data_r;
  logic [69:0] data_o;
  logic valid_m, valid_r, valid_o;
  logic ready_m, ready_r, ready_o;
  logic cc_m, cc_r, cc_o;
  logic fs_m, fs_r, fs_o;
  logic busy_m, busy_r, busy_o;
  logic err_m, err_r, err_o;

  logic [2:0] cc_w, rdy_w, busy_w, fs_w, rst_w;
  assign cc_w   = {cc_o, cc_r, cc_m};
  assign rdy_w  = {ready_o, ready_r, ready_m};
  assign busy_w = {busy_o, busy_r, busy_m};
  assign fs_w   = {fs_o, fs_r, fs_m};
  assign rst_w  = {rst_o, rst_r, rst_m};

  cc_stream_tx u_dut (
    .CLK_MCLK(clk), .reset(rst_m), .CBCLK(cbclk), .CLRCLK(lrclk),
    .cc_data(data_m), .cc_valid(valid_m), .cc_ready(ready_m), .CC(cc_m),
    .frame_start(fs_m), .busy(busy_m), .frame_err(err_m));

  cc_stream_tx #(.BITS(59), .REPEAT(1'b0)) u_dut_r0 (
    .CLK_MCLK(clk), .reset(rst_r), .CBCLK(cbclk), .CLRCLK(lrclk),
    .cc_data(data_r), .cc_valid(valid_r), .cc_ready(ready_r), .CC(cc_r),
    .frame_start(fs_r), .busy(busy_r), .frame_err(err_r));

  cc_stream_tx #(.BITS(70), .REPEAT(1'b1)) u_dut_ov (
    .CLK_MCLK(clk), .reset(rst_o), .CBCLK(cbclk), .CLRCLK(lrclk),
    .cc_data(data_o), .cc_valid(valid_o), .cc_ready(ready_o), .CC(cc_o),
    .frame_start(fs_o), .busy(busy_o), .frame_err(err_o));

  localparam logic [67:0] A_RAW = 68'h5_A5A5_A5A5_A5A5_A5A5;
  localparam logic [58:0] W_A = A_RAW[58:0];
  localparam logic [58:0] W_B = 59'h4_0000_0000_0000_01;
  localparam logic [58:0] W_C = 59'h3_FFFF_0000_FFFF_00;
  localparam logic [58:0] W_D = 59'h7_1234_5678_9ABC_DE;
  localparam logic [58:0] W_E = 59'h6_0123_4567_89AB_CD;
  localparam logic [69:0] W_G = 70'h2C_3C35_A5AF_0F01_2345;

  int checks = 0, failures = 0;
  logic [69:0] q_m[$], q_r[$], q_o[$];
  bit m_done = 0, r_done = 0, o_done = 0;
  int fs_cnt_m = 0, err_cnt_m = 0, fs_in_rst = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // CBCLK = 8 MCLK cycles, 64 CBCLK per CLRCLK; CLRCLK falls together with a CBCLK fall
  initial begin
    bus_cnt = 9'd500;
    lr_cnt  = 0;
    cbclk   = bus_cnt[2];
    lrclk   = bus_cnt[8];
    forever begin
      @(negedge clk);
      lr_prev = lrclk;
      bus_cnt = bus_cnt + 9'd1;
      cbclk   = bus_cnt[2];
      lrclk   = bus_cnt[8];
      if (lr_prev && !lrclk) lr_cnt++;
    end
  end

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Collects nbits from CC, sampling just before each CBCLK fall
  task automatic check_frame(input int k, input int nbits, input logic [69:0] exp,
                             input bit idle_chk, input string tag);
    logic [69:0] got = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge cbclk);
      got = {got[68:0], cc_w[k]};
    end
    chk({tag, "_word"}, got, exp);
    if (idle_chk) begin
      @(negedge cbclk);
      chk({tag, "_idle_zero"}, 70'(cc_w[k]), 70'd0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (fs_m) fs_cnt_m++;
      if (err_m) err_cnt_m++;
      for (int k = 0; k < 3; k++) if (rst_w[k] && fs_w[k]) fs_in_rst++;
    end
  end

  initial begin : mon_main
    logic [69:0] exp;
    for (int f = 0; f < 8; f++) begin
      do @(negedge clk); while (!fs_m);
      chk("m_busy_at_start", 70'(busy_m), 70'd1);
      if (q_m.size() == 0) begin
        checks++; failures++;
        $display("FAIL m_queue_empty actual=frame_start expected=no_frame");
      end else begin
        exp = q_m.pop_front();
        check_frame(0, 59, exp, 1'b1, "m_frame");
      end
    end
    m_done = 1;
  end

  initial begin : mon_r0
    logic [69:0] exp;
    for (int f = 0; f < 3; f++) begin
      do @(negedge clk); while (!fs_r);
      if (q_r.size() == 0) begin
        checks++; failures++;
        $display("FAIL r_queue_empty actual=frame_start expected=no_frame");
      end else begin
        exp = q_r.pop_front();
        check_frame(1, 59, exp, 1'b1, "r_frame");
      end
    end
    r_done = 1;
  end

  initial begin : mon_ov
    logic [69:0] exp;
    for (int f = 0; f < 2; f++) begin
      do @(negedge clk); while (!fs_o);
      chk("o_frame_err", 70'(err_o), (f > 0) ? 70'd1 : 70'd0);
      if (q_o.size() == 0) begin
        checks++; failures++;
        $display("FAIL o_queue_empty actual=frame_start expected=no_frame");
      end else begin
        exp = q_o.pop_front();
        check_frame(2, 64, exp, 1'b0, "o_frame");
      end
    end
    o_done = 1;
  end

  task automatic hs_m(input logic [58:0] d, output bit fs_at, output bit ok);
    ok = 0;
    fs_at = 0;
    @(negedge clk);
    data_m  = d;
    valid_m = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if (ready_m) begin
        fs_at = fs_m;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1 valid_m = 1'b0;
  endtask

  initial begin : stim
    bit fs_at, ok;
    rst_m = 1; rst_r = 1; rst_o = 1;
    valid_m = 0; valid_r = 0; valid_o = 0;
    data_m = '0; data_r = '0; data_o = '0;

    repeat (20) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_cc_%0d", k), 70'(cc_w[k]), 70'd0);
      chk($sformatf("rst_ready_%0d", k), 70'(rdy_w[k]), 70'd1);
      chk($sformatf("rst_busy_%0d", k), 70'(busy_w[k]), 70'd0);
    end
    chk("rst_no_frame_start", 70'(fs_in_rst), 70'd0);
    @(posedge clk);
    #1 rst_m = 0; rst_r = 0; rst_o = 0;

    // first words load while IDLE; REPEAT=1 resends A, REPEAT=0 sends zeros
    for (int i = 0; i < 4; i++) q_m.push_back(70'(W_A));
    q_r.push_back(70'(W_E)); q_r.push_back(70'd0); q_r.push_back(70'd0);
    q_o.push_back(W_G >> 6); q_o.push_back(W_G >> 6);
    @(negedge clk);
    data_m = W_A; valid_m = 1;
    data_r = W_E; valid_r = 1;
    data_o = W_G; valid_o = 1;
    @(posedge clk);
    #1 valid_m = 0; valid_r = 0; valid_o = 0;
    @(negedge clk);
    chk("m_ready_after_load", 70'(ready_m), 70'd0);
    chk("r_ready_after_load", 70'(ready_r), 70'd0);

    // reset the overrun instance in the middle of its third frame
    wait (lr_cnt == 4);
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("o_busy_mid_shift", 70'(busy_o), 70'd1);
    @(posedge clk);
    #1 rst_o = 1;
    @(posedge clk);
    @(negedge clk);
    chk("o_rst_cc", 70'(cc_o), 70'd0);
    chk("o_rst_busy", 70'(busy_o), 70'd0);
    chk("o_rst_ready", 70'(ready_o), 70'd1);

    // backpressure: B fills hold, C stalls until B is committed
    wait (lr_cnt == 5);
    repeat (10) @(posedge clk);
    q_m.push_back(70'(W_B));
    hs_m(W_B, fs_at, ok);
    chk("m_b_load", 70'(ok), 70'd1);
    q_m.push_back(70'(W_C));
    hs_m(W_C, fs_at, ok);
    chk("m_c_load", 70'(ok), 70'd1);
    chk("m_c_ready_with_commit", 70'(fs_at), 70'd1);
    chk("m_c_stall_frame", 70'(lr_cnt), 70'd6);

    // bypass: valid only during the internal lr_fall cycle
    wait (lr_cnt == 8);
    @(posedge clk);
    @(posedge clk);
    #1;
    q_m.push_back(70'(W_D));
    data_m = W_D; valid_m = 1;
    @(posedge clk);
    #1 valid_m = 0;
    @(negedge clk);
    chk("m_bypass_hold_empty", 70'(ready_m), 70'd1);
    q_m.push_back(70'(W_D));

    for (int i = 0; i < 3000 && !(m_done && r_done && o_done); i++) @(posedge clk);
    if (!(m_done && r_done && o_done)) begin
      checks++; failures++;
      $display("FAIL monitor_timeout actual=%0d%0d%0d expected=111", m_done, r_done, o_done);
    end
    chk("m_frame_start_count", 70'(fs_cnt_m), 70'd8);
    chk("m_no_frame_err", 70'(err_cnt_m), 70'd0);
    chk("m_queue_drained", 70'(q_m.size()), 70'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
